// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: func3 encodings and access FSM states.
package mem_stage_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane steering, byte enables, load extension and misalign/illegal detection.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_data_o,
    output logic        err_o
);
    logic [31:0] shifted;
    logic        misalign;
    logic        store_f3_ok;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (func3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {24'h0, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {16'h0, shifted[15:0]};
            default: load_data_o = shifted;
        endcase

        case (func3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = store_data_i;
            end
        endcase

        misalign    = ((func3_i[1:0] == 2'b01) && addr_lo_i[0])
                   || ((func3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
        store_f3_ok = (func3_i == F3_B) || (func3_i == F3_H) || (func3_i == F3_W);
        err_o       = (is_load_i  && (!load_f3_legal(func3_i) || misalign))
                   || (is_store_i && (!store_f3_ok || misalign));
    end
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access FSM with timeout, branch resolution and MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      func3_MEM,
    input  logic [XLEN-1:0] newPC_MEM,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] writeData_MEM,
    input  logic            isZero,
    input  logic            MemToReg_MEM,
    input  logic            RegWrite_MEM,
    input  logic            MemRead_MEM,
    input  logic            MemWrite_MEM,
    input  logic            branch_op_MEM,
    input  logic [4:0]      rd_MEM,
    mem_stage_if.master     dmem,
    output logic            stall_o,
    output logic            pcSrc_o,
    output logic [XLEN-1:0] branchTarget_o,
    output logic            fault_o,
    output logic [XLEN-1:0] readData_WB,
    output logic [XLEN-1:0] aluResult_WB,
    output logic [4:0]      rd_WB,
    output logic            MemToReg_WB,
    output logic            RegWrite_WB
);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    mem_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic        fault_q;

    logic        is_load, is_store, op, err, valid_op;
    logic        timeout, issue, done, fault_d;
    logic [31:0] load_data;

    // Both read and write set is handled as a load.
    assign is_load  = MemRead_MEM;
    assign is_store = MemWrite_MEM & ~MemRead_MEM;
    assign op       = is_load | is_store;

    load_store_align u_align (
        .func3_i      (func3_MEM),
        .addr_lo_i    (result[1:0]),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .store_data_i (writeData_MEM),
        .rdata_i      (dmem.dmem_rdata),
        .wdata_o      (dmem.dmem_wdata),
        .be_o         (dmem.dmem_be),
        .load_data_o  (load_data),
        .err_o        (err)
    );

    assign valid_op = op & ~err;
    assign timeout  = valid_op && (TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX);
    assign issue    = valid_op && !timeout && (state_q == MEM_IDLE || state_q == MEM_REQ);
    assign done     = valid_op && !timeout
                   && ((issue && dmem.dmem_gnt && is_store)
                    || (state_q == MEM_RESP && dmem.dmem_rvalid));
    assign fault_d  = (op & err) | timeout;

    assign stall_o         = reset & valid_op & ~done & ~timeout;
    assign dmem.dmem_req   = reset & issue;
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {result[31:2], 2'b00};
    assign branchTarget_o  = newPC_MEM;
    assign fault_o         = fault_q;
    assign pcSrc_o = reset & branch_op_MEM & ~op
                   & ((func3_MEM == F3_BEQ) ? isZero : (func3_MEM == F3_BNE) ? ~isZero : 1'b0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (timeout || done || !valid_op) begin
                state_q <= MEM_IDLE;
                cnt_q   <= '0;
            end else begin
                if (stall_o && TIMEOUT_CYC != 0)
                    cnt_q <= cnt_q + 1'b1;
                case (state_q)
                    MEM_IDLE: state_q <= (dmem.dmem_gnt && is_load) ? MEM_RESP : MEM_REQ;
                    MEM_REQ:  if (dmem.dmem_gnt && is_load) state_q <= MEM_RESP;
                    default:  state_q <= MEM_RESP;
                endcase
            end
        end
    end

    // Stalled or faulting instructions leave a bubble; data fields keep their last values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readData_WB  <= '0;
            aluResult_WB <= '0;
            rd_WB        <= '0;
            MemToReg_WB  <= 1'b0;
            RegWrite_WB  <= 1'b0;
        end else if (stall_o || fault_d) begin
            MemToReg_WB <= 1'b0;
            RegWrite_WB <= 1'b0;
        end else begin
            if (done && is_load)
                readData_WB <= load_data;
            aluResult_WB <= result;
            rd_WB        <= rd_MEM;
            MemToReg_WB  <= MemToReg_MEM;
            RegWrite_WB  <= RegWrite_MEM;
        end
    end
endmodule
